// File: rtl/i2c_burst_reader.sv
// I2C burst-read master: START, addr+W, reg, repeated START, addr+R,
// N bytes (ACK all but last, NACK last), STOP. Open-drain outputs only
// ever pull SCL/SDA low.
// Optional build macro I2C_CLK_STRETCH_EN adds scl_in and freezes the
// quarter timer while a slave holds SCL low after the master released it.
//
// state   | meaning
// IDLE    | waiting for start, lines released
// START   | START condition slot
// ADDR_W  | shifting out slave address + W
// ACK_AW  | slave ACK of address (write)
// REG     | shifting out register address
// ACK_REG | slave ACK of register address
// RSTART  | repeated START slot
// ADDR_R  | shifting out slave address + R
// ACK_AR  | slave ACK of address (read)
// READ    | shifting in one data byte
// MACK    | master ACK (more bytes) or NACK (last byte)
// STOP    | STOP condition slot
// FIN     | one-cycle done pulse, back to IDLE
module i2c_burst_reader #(
  parameter int CLK_DIV   = 125,
  parameter int MAX_BYTES = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       slave_addr,
  input  logic [7:0]       reg_addr,
  input  logic [CNT_W-1:0] byte_cnt,
  output logic             busy,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             ack_err,
  output logic             scl_oe,
  output logic             sda_oe,
`ifdef I2C_CLK_STRETCH_EN
  input  logic             scl_in,
`endif
  input  logic             sda_in
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_AW, REG, ACK_REG, RSTART,
    ADDR_R, ACK_AR, READ, MACK, STOP, FIN
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] qdiv;
  logic [1:0]       q;
  logic [2:0]       bit_idx;
  logic [6:0]       addr_q;
  logic [7:0]       reg_q;
  logic [CNT_W-1:0] rem;
  logic [7:0]       shreg;
  logic             err;

  logic             hold;
  logic             tick;
  logic             sample;
  logic             slot_end;
  logic [7:0]       tx_byte;
  logic [CNT_W-1:0] len;
  logic             scl_nxt;
  logic             sda_nxt;

  // The timer only freezes once our own SCL release has taken effect, so an
  // unstretched slot never loses a cycle to the output register delay.
`ifdef I2C_CLK_STRETCH_EN
  assign hold = !scl_oe && !scl_in && (state != IDLE);
`else
  assign hold = 1'b0;
`endif

  assign tick     = (qdiv == '0) && !hold;
  assign sample   = tick && (q == 2'd2);
  assign slot_end = tick && (q == 2'd3);

  // Byte currently being shifted out in the write phases
  always_comb begin
    tx_byte = reg_q;
    if (state == ADDR_W)      tx_byte = {addr_q, 1'b0};
    else if (state == ADDR_R) tx_byte = {addr_q, 1'b1};
  end

  // Burst length with 0 promoted to 1 and oversize clamped
  always_comb begin
    len = byte_cnt;
    if (byte_cnt == '0)                      len = CNT_W'(1);
    else if (byte_cnt > CNT_W'(MAX_BYTES))   len = CNT_W'(MAX_BYTES);
  end

  // Line drive pattern for the current state and quarter
  always_comb begin
    scl_nxt = (q == 2'd0);
    sda_nxt = 1'b0;
    case (state)
      IDLE, FIN:           scl_nxt = 1'b0;
      START: begin
        scl_nxt = 1'b0;
        sda_nxt = q[1];
      end
      RSTART:              sda_nxt = q[1];
      ADDR_W, REG, ADDR_R: sda_nxt = ~tx_byte[bit_idx];
      MACK:                sda_nxt = (rem != CNT_W'(1));
      STOP:                sda_nxt = ~q[1];
      default:             ;
    endcase
  end

  // Sequencer: quarter timer, bit/byte counters and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      qdiv     <= DIV_LOAD;
      q        <= 2'd0;
      bit_idx  <= 3'd7;
      addr_q   <= '0;
      reg_q    <= '0;
      rem      <= '0;
      shreg    <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (state != IDLE && state != FIN && !hold) begin
        if (qdiv == '0) begin
          qdiv <= DIV_LOAD;
          q    <= q + 2'd1;
        end else begin
          qdiv <= qdiv - 1'b1;
        end
      end
      case (state)
        IDLE: if (start) begin
          addr_q  <= slave_addr;
          reg_q   <= reg_addr;
          rem     <= len;
          err     <= 1'b0;
          ack_err <= 1'b0;
          busy    <= 1'b1;
          qdiv    <= DIV_LOAD;
          q       <= 2'd0;
          bit_idx <= 3'd7;
          state   <= START;
        end
        START:  if (slot_end) state <= ADDR_W;
        RSTART: if (slot_end) state <= ADDR_R;
        ADDR_W, REG, ADDR_R: if (slot_end) begin
          bit_idx <= bit_idx - 3'd1;
          if (bit_idx == 3'd0)
            state <= (state == ADDR_W) ? ACK_AW : (state == REG) ? ACK_REG : ACK_AR;
        end
        ACK_AW, ACK_REG, ACK_AR: begin
          if (sample) err <= sda_in;
          if (slot_end) begin
            if (err)                   state <= STOP;
            else if (state == ACK_AW)  state <= REG;
            else if (state == ACK_REG) state <= RSTART;
            else                       state <= READ;
          end
        end
        READ: begin
          if (sample) shreg <= {shreg[6:0], sda_in};
          if (slot_end) begin
            bit_idx <= bit_idx - 3'd1;
            if (bit_idx == 3'd0) begin
              rd_data  <= shreg;
              rd_valid <= 1'b1;
              state    <= MACK;
            end
          end
        end
        MACK: if (slot_end) begin
          if (rem == CNT_W'(1)) begin
            state <= STOP;
          end else begin
            rem   <= rem - CNT_W'(1);
            state <= READ;
          end
        end
        STOP: if (slot_end) state <= FIN;
        FIN: begin
          done    <= 1'b1;
          ack_err <= err;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered open-drain enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
    end else begin
      scl_oe <= scl_nxt;
      sda_oe <= sda_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_burst_reader.sv
// Directed bench for i2c_burst_reader with a behavioural I2C slave.
module tb_i2c_burst_reader;
  localparam int CD   = 4;
  localparam int MB   = 16;
  localparam int CW   = 5;
  localparam int SLOT = 4 * CD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0;
  logic [6:0]    slave_addr = '0;
  logic [7:0]    reg_addr = '0;
  logic [CW-1:0] byte_cnt = '0;
  logic          busy, rd_valid, done, ack_err, scl_oe, sda_oe;
  logic [7:0]    rd_data;

  logic s_sda  = 1'b1;
  logic s_hold = 1'b0;
  wire  scl_line = ~scl_oe & ~s_hold;
  wire  sda_line = ~sda_oe & s_sda;
`ifdef I2C_CLK_STRETCH_EN
  wire  scl_in = scl_line;
`endif

  always #5 clk = ~clk;

  i2c_burst_reader #(.CLK_DIV(CD), .MAX_BYTES(MB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .slave_addr(slave_addr),
    .reg_addr(reg_addr), .byte_cnt(byte_cnt), .busy(busy), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .ack_err(ack_err), .scl_oe(scl_oe),
    .sda_oe(sda_oe),
`ifdef I2C_CLK_STRETCH_EN
    .scl_in(scl_in),
`endif
    .sda_in(sda_line));

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT-side monitors
  logic [7:0] rdq[$];
  int   done_cnt = 0, done_cyc = 0;
  logic err_at_done = 1'b0;
  always @(negedge clk) begin
    if (rd_valid) rdq.push_back(rd_data);
    if (done) begin
      done_cnt    <= done_cnt + 1;
      done_cyc    <= cyc;
      err_at_done <= ack_err;
    end
  end

  // Behavioural slave
  logic       present = 1'b1;
  logic [6:0] saddr = 7'h68;
  logic [7:0] txd[16];
  logic       stretch_en = 1'b0;
  logic [3:0] cnt = '0;
  logic [3:0] idx = '0;
  int         byte_no = 0, starts = 0, stops = 0, hcnt = 0;
  logic [7:0] sh = '0;
  logic       tx = 1'b0, addressed = 1'b0, rdmode = 1'b0, mack = 1'b1, arm = 1'b0;
  logic       scl_l = 1'b1, sda_l = 1'b1;
  logic [7:0] wq[$];
  logic       mq[$];

  always @(negedge clk) begin
    scl_l <= scl_line;
    sda_l <= sda_line;
    if (!rst_n) begin
      s_sda <= 1'b1; s_hold <= 1'b0; tx <= 1'b0; addressed <= 1'b0;
      cnt <= '0; arm <= 1'b0;
    end else begin
      if (s_hold) begin
        hcnt <= hcnt - 1;
        if (hcnt == 1) s_hold <= 1'b0;
      end else if (arm && !scl_oe) begin
        s_hold <= 1'b1; hcnt <= 500; arm <= 1'b0;
      end
      if (scl_line && scl_l && sda_l && !sda_line) begin
        starts <= starts + 1; cnt <= '0; byte_no <= 0;
        tx <= 1'b0; addressed <= 1'b0; s_sda <= 1'b1;
      end else if (scl_line && scl_l && !sda_l && sda_line) begin
        stops <= stops + 1; tx <= 1'b0; s_sda <= 1'b1;
      end else if (scl_line && !scl_l) begin
        if (!tx && cnt < 4'd8) sh <= {sh[6:0], sda_line};
        if (!tx && cnt == 4'd7) begin
          wq.push_back({sh[6:0], sda_line});
          if (byte_no == 0) begin
            addressed <= present && (sh[6:0] == saddr);
            rdmode    <= sda_line;
          end
        end
        if (tx && cnt == 4'd8) begin
          mq.push_back(sda_line);
          mack <= sda_line;
        end
        cnt <= cnt + 4'd1;
      end else if (!scl_line && scl_l) begin
        if (cnt == 4'd9) begin
          cnt <= '0;
          byte_no <= byte_no + 1;
          if (!tx && byte_no == 0 && addressed && rdmode) begin
            tx <= 1'b1; idx <= '0; s_sda <= txd[0][7];
          end else if (tx && !mack) begin
            idx <= idx + 4'd1; s_sda <= txd[idx + 4'd1][7];
          end else begin
            tx <= 1'b0; s_sda <= 1'b1;
          end
        end else if (cnt == 4'd8) begin
          s_sda <= (!tx && addressed) ? 1'b0 : 1'b1;
        end else if (tx) begin
          s_sda <= txd[idx][3'(4'd7 - cnt)];
        end else begin
          s_sda <= 1'b1;
        end
        if (stretch_en && !tx && byte_no == 1 && cnt == 4'd4) arm <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int d0, r0, w0, m0, s0, acc_cyc;

  task automatic launch(input logic [6:0] a, input logic [7:0] r, input logic [CW-1:0] n);
    d0 = done_cnt; r0 = rdq.size(); w0 = wq.size(); m0 = mq.size(); s0 = stops;
    @(negedge clk);
    slave_addr = a; reg_addr = r; byte_cnt = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output int lat);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    check("done_seen", done_cnt - d0, 1);
    lat = done_cyc - acc_cyc;
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) txd[i] = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single-byte WHO_AM_I read
    txd[0] = 8'h68;
    launch(7'h68, 8'h75, 5'd1);
    check("t1_busy", busy, 1);
    wait_done(4000, lat);
    check("t1_lat", lat, 39 * SLOT + 1);
    check("t1_wbytes", wq.size() - w0, 3);
    check("t1_w0", wq[w0], 8'hD0);
    check("t1_w1", wq[w0 + 1], 8'h75);
    check("t1_w2", wq[w0 + 2], 8'hD1);
    check("t1_nrd", rdq.size() - r0, 1);
    check("t1_rd", rdq[r0], 8'h68);
    check("t1_nmack", mq.size() - m0, 1);
    check("t1_nack_last", mq[m0], 1);
    check("t1_err", err_at_done, 0);
    check("t1_stop", stops - s0, 1);
    check("t1_busy_end", busy, 0);
    check("t1_oe", {scl_oe, sda_oe}, 0);

    // 14-byte burst from 0x3B
    for (int i = 0; i < 16; i++) txd[i] = 8'(i);
    launch(7'h68, 8'h3B, 5'd14);
    wait_done(6000, lat);
    check("t2_lat", lat, (30 + 9 * 14) * SLOT + 1);
    check("t2_reg", wq[w0 + 1], 8'h3B);
    check("t2_nrd", rdq.size() - r0, 14);
    for (int i = 0; i < 14; i++) check("t2_rd", rdq[r0 + i], i);
    for (int i = 0; i < 14; i++) check("t2_mack", mq[m0 + i], (i == 13) ? 1 : 0);
    check("t2_stop", stops - s0, 1);
    check("t2_err", err_at_done, 0);

    // absent slave
    present = 1'b0;
    launch(7'h68, 8'h75, 5'd1);
    wait_done(4000, lat);
    check("t3_lat", lat, 11 * SLOT + 1);
    check("t3_err", err_at_done, 1);
    check("t3_nrd", rdq.size() - r0, 0);
    check("t3_wbytes", wq.size() - w0, 1);
    check("t3_stop", stops - s0, 1);
    repeat (10) @(negedge clk);
    check("t3_err_hold", ack_err, 1);
    check("t3_oe", {scl_oe, sda_oe}, 0);
    present = 1'b1;

    // start while busy is ignored
    txd[0] = 8'h5A;
    launch(7'h68, 8'h75, 5'd1);
    check("t4_err_clr", ack_err, 0);
    repeat (40) @(negedge clk);
    slave_addr = 7'h50; reg_addr = 8'h11; byte_cnt = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4000, lat);
    check("t4_lat", lat, 39 * SLOT + 1);
    check("t4_w0", wq[w0], 8'hD0);
    check("t4_w1", wq[w0 + 1], 8'h75);
    check("t4_w2", wq[w0 + 2], 8'hD1);
    check("t4_rd", rdq[r0], 8'h5A);
    repeat (20) @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_ndone", done_cnt - d0, 1);

    // byte_cnt boundaries
    launch(7'h68, 8'h00, 5'd0);
    wait_done(4000, lat);
    check("c0_lat", lat, 39 * SLOT + 1);
    check("c0_nrd", rdq.size() - r0, 1);
    for (int i = 0; i < 16; i++) txd[i] = 8'(8'hA0 + i);
    launch(7'h68, 8'h00, 5'd20);
    wait_done(6000, lat);
    check("c20_lat", lat, (30 + 9 * MB) * SLOT + 1);
    check("c20_nrd", rdq.size() - r0, MB);
    check("c20_last", rdq[r0 + MB - 1], 8'hAF);

    // reset in the middle of READ
    launch(7'h68, 8'h3B, 5'd3);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rdq.size() != r0) break;
    end
    check("t5_first_rd", rdq.size() - r0, 1);
    repeat (2 * SLOT) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_scl_oe", scl_oe, 0);
    check("t5_sda_oe", sda_oe, 0);
    check("t5_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    txd[0] = 8'h68;
    launch(7'h68, 8'h75, 5'd1);
    wait_done(4000, lat);
    check("t5_lat", lat, 39 * SLOT + 1);
    check("t5_rd", rdq[r0], 8'h68);
    check("t5_err", err_at_done, 0);

`ifdef I2C_CLK_STRETCH_EN
    stretch_en = 1'b1;
    launch(7'h68, 8'h75, 5'd1);
    wait_done(4000, lat);
    stretch_en = 1'b0;
    check("st_lat", lat, 39 * SLOT + 1 + 500);
    check("st_reg", wq[w0 + 1], 8'h75);
    check("st_rd", rdq[r0], 8'h68);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
